// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: debounced set/clear command generator for a downstream SR flop.
// Latency: DEB_CYCLES+2 edges from first input sample to s/r pulse (2 sync + debounce).
// Backpressure: none; requests arriving while busy are ignored, a held input yields one command.
// Optional feature macro: SR_CMD_CONFLICT_EN (adds conflict port; simultaneous set+clear pulses conflict instead of r).
module sr_cmd_gen #(
  parameter int DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_in,
  input  logic       clr_in,
  output logic       s,
  output logic       r,
  output logic       busy,
  output logic [7:0] cmd_cnt
`ifdef SR_CMD_CONFLICT_EN
  ,
  output logic       conflict
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    FIRE     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // Reload value for the debounce / release counter.
  localparam logic [7:0] DEB_LOAD = 8'(DEB_CYCLES - 1);

  // Synchronizer stages.
  logic set_meta_q, set_sy_q;
  logic clr_meta_q, clr_sy_q;
  logic set_sy, clr_sy;

  // FSM state and registered outputs.
  state_t     state_q, state_d;
  logic [1:0] cand_q, cand_d;
  logic [7:0] deb_cnt_q, deb_cnt_d;
  logic [7:0] cmd_cnt_q, cmd_cnt_d;
  logic       s_q, s_d;
  logic       r_q, r_d;
  logic       busy_q, busy_d;
`ifdef SR_CMD_CONFLICT_EN
  logic       conflict_q, conflict_d;
`endif

  logic [1:0] pat;

  assign set_sy = set_sy_q;
  assign clr_sy = clr_sy_q;
  assign pat    = {set_sy, clr_sy};

  // Next-state logic: debounce the synchronized pattern, fire once, wait for full release.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    deb_cnt_d = deb_cnt_q;
    cmd_cnt_d = cmd_cnt_q;
    s_d       = 1'b0;
    r_d       = 1'b0;
`ifdef SR_CMD_CONFLICT_EN
    conflict_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pat != 2'b00) begin
          cand_d    = pat;
          deb_cnt_d = DEB_LOAD;
          state_d   = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (pat != cand_q) begin
          // Input changed before it was stable long enough: drop it silently.
          state_d = IDLE;
        end else if (deb_cnt_q == 8'd0) begin
          // Output registers are loaded on the edge entering FIRE.
          state_d = FIRE;
          case (cand_q)
            2'b10: begin
              s_d       = 1'b1;
              cmd_cnt_d = cmd_cnt_q + 8'd1;
            end
            2'b01: begin
              r_d       = 1'b1;
              cmd_cnt_d = cmd_cnt_q + 8'd1;
            end
            2'b11: begin
`ifdef SR_CMD_CONFLICT_EN
              conflict_d = 1'b1;
`else
              // Clear wins when both requests are seen together.
              r_d       = 1'b1;
              cmd_cnt_d = cmd_cnt_q + 8'd1;
`endif
            end
            default: ;
          endcase
        end else begin
          deb_cnt_d = deb_cnt_q - 8'd1;
        end
      end
      FIRE: begin
        state_d   = RELEASE;
        deb_cnt_d = DEB_LOAD;
      end
      RELEASE: begin
        // Both inputs must stay low DEB_CYCLES consecutive cycles; any high restarts.
        if (pat != 2'b00) begin
          deb_cnt_d = DEB_LOAD;
        end else if (deb_cnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          deb_cnt_d = deb_cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, synchronizer and output registers; reset has priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      set_meta_q <= 1'b0;
      set_sy_q   <= 1'b0;
      clr_meta_q <= 1'b0;
      clr_sy_q   <= 1'b0;
      state_q    <= IDLE;
      cand_q     <= 2'b00;
      deb_cnt_q  <= 8'd0;
      cmd_cnt_q  <= 8'd0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      busy_q     <= 1'b0;
`ifdef SR_CMD_CONFLICT_EN
      conflict_q <= 1'b0;
`endif
    end else begin
      set_meta_q <= set_in;
      set_sy_q   <= set_meta_q;
      clr_meta_q <= clr_in;
      clr_sy_q   <= clr_meta_q;
      state_q    <= state_d;
      cand_q     <= cand_d;
      deb_cnt_q  <= deb_cnt_d;
      cmd_cnt_q  <= cmd_cnt_d;
      s_q        <= s_d;
      r_q        <= r_d;
      busy_q     <= busy_d;
`ifdef SR_CMD_CONFLICT_EN
      conflict_q <= conflict_d;
`endif
    end
  end

  assign s       = s_q;
  assign r       = r_q;
  assign busy    = busy_q;
  assign cmd_cnt = cmd_cnt_q;
`ifdef SR_CMD_CONFLICT_EN
  assign conflict = conflict_q;
`endif

endmodule
